// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, framing constants
// and the state-to-handshake decode used by the top.
package prog_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_WORD_HI = 4'd3,
    ST_WORD_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CHK     = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
  localparam int         LEN_HI_W         = 4;
  localparam int         LEN_LO_W         = 8;
  localparam int         LEN_W            = LEN_HI_W + LEN_LO_W;
  localparam logic [7:0] LEN_HI_RSVD_MASK = 8'hF0;
  localparam logic [7:0] WHI_RSVD_MASK    = 8'hC0;

  // Handshake: a byte is consumed on a rising edge where in_valid & in_ready;
  // in_ready is registered, so it reflects the state currently held.
  function automatic logic state_accepts(state_t s);
    return s inside {ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_WORD_HI, ST_WORD_LO, ST_CHK, ST_ERR};
  endfunction

  function automatic logic state_busy(state_t s);
    return !(s inside {ST_IDLE, ST_ERR});
  endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// Mod-256 running sum of frame bytes; cleared on SYNC, compared against the
// trailing checksum byte.
module prog_loader_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic       o_match
);

  logic [7:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_byte;
    end
  end

  assign o_match = (i_byte == r_sum);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for CPU program memory; holds the CPU in reset while loading.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 11,
  parameter int         DATA_W    = 14,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        dbg_state
);

  localparam int CNT_W   = ADDR_W + 1;
  localparam int MAX_LEN = 2 ** ADDR_W;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_in_ready;
  logic                r_pm_we;
  logic [ADDR_W-1:0]   r_pm_addr;
  logic [DATA_W-1:0]   r_pm_wdata;
  logic                r_cpu_hold;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [LEN_HI_W-1:0] r_len_hi;
  logic [LEN_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic [5:0]          r_whi;

  logic                w_take;
  logic                w_is_sync;
  logic [LEN_W-1:0]    w_len;
  logic                w_len_bad;
  logic                w_last;
  logic                w_csum_ok;

  assign w_take    = in_valid & r_in_ready;
  assign w_is_sync = (in_data == SYNC_BYTE);
  assign w_len     = {r_len_hi, in_data};
  assign w_len_bad = (w_len == '0) || (int'(w_len) > MAX_LEN);
  // cnt is one bit wider than the address so a full 2**ADDR_W image ends without wrap.
  assign w_last    = (int'(r_cnt) == int'(r_len) - 1);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic w_csum_clr;
  logic w_csum_add;

  assign w_csum_clr = w_take & w_is_sync & (r_state inside {ST_IDLE, ST_ERR});
  assign w_csum_add = w_take & (r_state inside {ST_LEN_HI, ST_LEN_LO, ST_WORD_HI, ST_WORD_LO});

  prog_loader_csum u_csum (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_csum_clr),
    .i_add   (w_csum_add),
    .i_byte  (in_data),
    .o_match (w_csum_ok)
  );
`else
  assign w_csum_ok = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_take && w_is_sync) w_state_nxt = ST_LEN_HI;
      ST_LEN_HI:  if (w_take) w_state_nxt = |(in_data & LEN_HI_RSVD_MASK) ? ST_ERR : ST_LEN_LO;
      ST_LEN_LO:  if (w_take) w_state_nxt = w_len_bad ? ST_ERR : ST_WORD_HI;
      ST_WORD_HI: if (w_take) w_state_nxt = |(in_data & WHI_RSVD_MASK) ? ST_ERR : ST_WORD_LO;
      ST_WORD_LO: if (w_take) w_state_nxt = ST_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_WRITE:   w_state_nxt = w_last ? ST_CHK : ST_WORD_HI;
`else
      ST_WRITE:   w_state_nxt = w_last ? ST_DONE : ST_WORD_HI;
`endif
      ST_CHK:     if (w_take) w_state_nxt = w_csum_ok ? ST_DONE : ST_ERR;
      ST_DONE:    w_state_nxt = ST_IDLE;
      ST_ERR:     if (w_take && w_is_sync) w_state_nxt = ST_LEN_HI;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_pm_we    <= 1'b0;
      r_pm_addr  <= '0;
      r_pm_wdata <= '0;
      r_cpu_hold <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_whi      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= state_accepts(w_state_nxt);
      r_busy     <= state_busy(w_state_nxt);
      r_done     <= (w_state_nxt == ST_DONE);
      r_err      <= (w_state_nxt == ST_ERR);
      r_pm_we    <= 1'b0;

      // The CPU is released on the edge leaving DONE; an error keeps it held.
      if (r_state == ST_DONE) begin
        r_cpu_hold <= 1'b0;
      end else if (w_take && w_is_sync && w_state_nxt == ST_LEN_HI) begin
        r_cpu_hold <= 1'b1;
      end

      case (r_state)
        ST_LEN_HI:  if (w_take) r_len_hi <= in_data[LEN_HI_W-1:0];
        ST_LEN_LO: begin
          if (w_take) begin
            r_len <= w_len;
            r_cnt <= '0;
          end
        end
        ST_WORD_HI: if (w_take) r_whi <= in_data[5:0];
        ST_WORD_LO: begin
          if (w_take) begin
            r_pm_we    <= 1'b1;
            r_pm_addr  <= r_cnt[ADDR_W-1:0];
            r_pm_wdata <= {r_whi, in_data};
          end
        end
        ST_WRITE:   if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign pm_we     = r_pm_we;
  assign pm_addr   = r_pm_addr;
  assign pm_wdata  = r_pm_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame table with expected writes/status, plus
// hand sequences for WRITE/DONE timing, a full-size image and reset mid-frame.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        pm_we;
  logic [10:0] pm_addr;
  logic [13:0] pm_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  dbg_state;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pm_we     (pm_we),
    .pm_addr   (pm_addr),
    .pm_wdata  (pm_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_e;

  typedef struct {
    int              n;
    logic [0:7][7:0] b;
    int              nw;
    logic [13:0]     w0;
    logic [13:0]     w1;
    logic            exp_done;
    logic            exp_err;
  } frame_t;

  frame_t frames[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every pm_we cycle must match the head of exp_q
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("pm_write", 32'({pm_addr, pm_wdata}), 32'(mon_e));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // driver: called just after a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int idx);
    frame_t     f;
    int         base;
    logic [7:0] s;
    bit         started;
    f       = frames[idx];
    base    = done_cnt;
    s       = 8'h00;
    started = 1'b0;
    if (f.nw > 0) exp_q.push_back({11'd0, f.w0});
    if (f.nw > 1) exp_q.push_back({11'd1, f.w1});
    for (int k = 0; k < f.n; k++) begin
      if (started) s = s + f.b[k];
      else if (f.b[k] == 8'hA5) started = 1'b1;
      send_byte(f.b[k]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (f.exp_done) send_byte(s);
`endif
    repeat (4) @(negedge clk);
    chk($sformatf("f%0d_writes_left", idx), 32'(exp_q.size()), 32'd0);
    chk($sformatf("f%0d_done_pulses", idx), 32'(done_cnt - base), 32'(f.exp_done));
    chk($sformatf("f%0d_err", idx), 32'(err), 32'(f.exp_err));
    chk($sformatf("f%0d_cpu_hold", idx), 32'(cpu_hold), 32'(!f.exp_done));
    chk($sformatf("f%0d_busy", idx), 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_big();
    int          base;
    logic [7:0]  s;
    logic [13:0] w;
    logic [7:0]  hi;
    base = done_cnt;
    s    = 8'h08;
    send_byte(8'hA5);
    send_byte(8'h08);
    send_byte(8'h00);
    for (int i = 0; i < 2048; i++) begin
      w  = 14'(i ^ (i << 3));
      hi = {2'b00, w[13:8]};
      s  = s + hi + w[7:0];
      exp_q.push_back({11'(i), w});
      send_byte(hi);
      send_byte(w[7:0]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(s);
`endif
    repeat (4) @(negedge clk);
    chk("big_writes_left", 32'(exp_q.size()), 32'd0);
    chk("big_done_pulses", 32'(done_cnt - base), 32'd1);
    chk("big_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("big_err", 32'(err), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    frames[0] = '{7, {8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h00}, 2, 14'h3005, 14'h3E03, 1'b1, 1'b0};
    frames[1] = '{7, {8'h11, 8'h22, 8'hA5, 8'h00, 8'h01, 8'h28, 8'h00, 8'h00}, 1, 14'h2800, 14'h0000, 1'b1, 1'b0};
    frames[2] = '{3, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 14'h0000, 14'h0000, 1'b0, 1'b1};
    frames[3] = '{5, {8'hA5, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00}, 1, 14'h00FF, 14'h0000, 1'b1, 1'b0};
    frames[4] = '{5, {8'hA5, 8'h00, 8'h01, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 14'h0000, 14'h0000, 1'b0, 1'b1};
    frames[5] = '{2, {8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 14'h0000, 14'h0000, 1'b0, 1'b1};
    frames[6] = '{5, {8'hA5, 8'h00, 8'h01, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00}, 1, 14'h12A5, 14'h0000, 1'b1, 1'b0};
    frames[7] = '{3, {8'hA5, 8'h08, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 14'h0000, 14'h0000, 1'b0, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_pm_we", 32'(pm_we), 32'd0);
    chk("rst_pm_addr", 32'(pm_addr), 32'd0);
    chk("rst_pm_wdata", 32'(pm_wdata), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dbg_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    #1;
    chk("release_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("first_clk_in_ready", 32'(in_ready), 32'd1);

`ifndef PROG_LOADER_CHECKSUM_EN
    // WRITE / DONE timing with the sender holding a byte across the stall
    base = done_cnt;
    exp_q.push_back({11'd0, 14'h0102});
    send_byte(8'hA5);
    chk("sync_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("sync_busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("wr_pm_we", 32'(pm_we), 32'd1);
    chk("wr_in_ready", 32'(in_ready), 32'd0);
    chk("wr_done", 32'(done), 32'd0);
    in_data  = 8'h77;
    in_valid = 1'b1;
    @(negedge clk);
    chk("dn_done", 32'(done), 32'd1);
    chk("dn_pm_we", 32'(pm_we), 32'd0);
    chk("dn_in_ready", 32'(in_ready), 32'd0);
    chk("dn_cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("timing_done_pulses", 32'(done_cnt - base), 32'd1);
    @(negedge clk);
    chk("junk_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    chk("timing_writes_left", 32'(exp_q.size()), 32'd0);
`else
    // checksum accepted, then checksum rejected after the write already happened
    base = done_cnt;
    exp_q.push_back({11'd0, 14'h3005});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h30); send_byte(8'h05); send_byte(8'h36);
    repeat (4) @(negedge clk);
    chk("csum_ok_done", 32'(done_cnt - base), 32'd1);
    chk("csum_ok_err", 32'(err), 32'd0);
    chk("csum_ok_hold", 32'(cpu_hold), 32'd0);
    base = done_cnt;
    exp_q.push_back({11'd0, 14'h3005});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h30); send_byte(8'h05); send_byte(8'h37);
    repeat (4) @(negedge clk);
    chk("csum_bad_done", 32'(done_cnt - base), 32'd0);
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
    chk("csum_bad_writes_left", 32'(exp_q.size()), 32'd0);
`endif

    // frame table
    for (int i = 0; i < 8; i++) run_frame(i);
    run_frame(3);

    // largest image: last address 0x7FF, no wrap
    run_big();

    // reset mid-payload
    exp_q.push_back({11'd0, 14'h1234});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h12); send_byte(8'h34);
    in_data  = 8'h05;
    in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pm_we", 32'(pm_we), 32'd0);
    chk("mid_rst_pm_wdata", 32'(pm_wdata), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rel_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("mid_rel_first_clk", 32'(in_ready), 32'd1);
    run_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
